// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall scheduler: load-use, taken-branch flush, MUL/DIV occupancy, debug halt.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             pc_we,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  if (MDU_LAT < 2 || MDU_LAT > 15) begin : g_bad_lat
    $error("hazard_stall_ctrl: MDU_LAT must be within 2..15");
  end

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       halt_ack_q;
  logic       load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_busy    = 1'b0;
    case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          // Squashes the ID instruction, so halt/MDU requests wait a cycle.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (halt_req) begin
          pc_we       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = StHalt;
        end else if (load_use) begin
          pc_we       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_valid && id_mdu_start) begin
          state_d = StMduWait;
          cnt_d   = 4'(MDU_LAT - 1);
        end
      end
      StMduWait: begin
        pc_we       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        mdu_busy    = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = halt_req ? StHalt : StRun;
        end
      end
      StHalt: begin
        pc_we       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (!halt_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (rst) begin
      pc_we       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      mdu_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= 4'd0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halt_ack_q <= (state_d == StHalt);
    end
  end

  assign halt_ack = halt_ack_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_acc;

  assign flush_acc = (state_q == StRun) && ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_acc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

  // EX holds the MDU op or a bubble, so a taken branch here is a pipeline bug.
  a_no_branch_in_mdu: assert property (@(posedge clk) disable iff (rst)
    !((state_q == StMduWait) && ex_branch_taken));

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control scheduler driving the enable/flush inputs of the IF/ID register, the PC write enable and the ID/EX bubble insert.
- Resolves load-use hazards, taken-branch flushes, multi-cycle MUL/DIV occupancy and external debug halt into one prioritised set of per-cycle controls.
- Sits beside the decode stage; outputs are combinational from registered state plus current-cycle inputs, so they act on the same clock edge.

Parameters:
- MDU_LAT, 4, cycles a MUL/DIV occupies EX (legal 2..15)
- CNT_W, 16, width of perf counters (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_uses_rt  in  1  ID instruction reads rt
- id_mdu_start  in  1  ID instruction is MUL/DIV
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  load destination in EX
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- halt_req  in  1  debug freeze request (level)
- halt_ack  out  1  pipeline frozen
- pc_we  out  1  PC write enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID flush
- id_ex_flush  out  1  bubble into ID/EX
- mdu_busy  out  1  MDU_WAIT active
- stall_cycles  out  CNT_W  perf: stalled cycles
- flush_count  out  CNT_W  perf: branch flushes

Behaviour:
- Reset (async, rst=1): state=RUN, counter=0, halt_ack=0, perf counters=0. Outputs during reset: pc_we=0, if_id_en=0, if_id_flush=0, id_ex_flush=0, mdu_busy=0.
- States: RUN, MDU_WAIT, HALT (2-bit encoding).
- Default RUN outputs: pc_we=1, if_id_en=1, if_id_flush=0, id_ex_flush=0.
- load_use = ex_memread & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN priority, highest first:
  1. ex_branch_taken: pc_we=1, if_id_flush=1, id_ex_flush=1; state stays RUN. halt_req and id_mdu_start are ignored this cycle, since the ID instruction is squashed.
  2. halt_req: pc_we=0, if_id_en=0, id_ex_flush=1; next state HALT.
  3. load_use: pc_we=0, if_id_en=0, id_ex_flush=1; state stays RUN. An MDU instruction is not started while load_use holds.
  4. id_valid & id_mdu_start: normal advance this cycle; next state MDU_WAIT, counter<=MDU_LAT-1.
- MDU_WAIT:
  - pc_we=0, if_id_en=0, id_ex_flush=1, mdu_busy=1; counter decrements each cycle.
  - When counter==1: next state is HALT if halt_req, else RUN.
  - ex_branch_taken is ignored (EX holds the MDU op or bubbles). Sim-only assertion flags it.
- HALT:
  - pc_we=0, if_id_en=0, id_ex_flush=1, halt_ack=1 (registered, so it rises one cycle after the request is accepted).
  - halt_req=0 moves the state to RUN; halt_ack falls on the same edge.
- halt_req deassert before acceptance (e.g. during MDU_WAIT) cancels the request silently.
- rst mid-MDU_WAIT or mid-HALT: immediate return to RUN with the reset values above.
- Counter width is 4 bits; MDU_LAT outside 2..15 is an elaboration error.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments every cycle pc_we==0 outside reset.
  - flush_count increments on each accepted ex_branch_taken (RUN only).
  - Both saturate at all-ones and are cleared only by rst.
- Undefined: both ports are tied to 0 and no counter logic exists.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_valid=1 for one cycle -> pc_we=0, if_id_en=0, id_ex_flush=1 that cycle. Next cycle (ex_memread=0) -> pc_we=1, if_id_en=1. Repeat with ex_rt=0 -> no stall.
- Branch vs load-use in the same cycle: ex_branch_taken=1 with load_use true -> pc_we=1, if_id_flush=1, id_ex_flush=1. flush_count 0->1 when the macro is defined.
- MDU, MDU_LAT=4: id_mdu_start=1 -> exactly 3 cycles of mdu_busy=1, pc_we=0, then RUN with pc_we=1. stall_cycles=3.
- Halt during MDU: halt_req=1 raised in the 2nd MDU_WAIT cycle -> stays in MDU_WAIT to completion, then HALT. halt_ack=1 the following cycle; halt_req=0 -> RUN, pc_we=1.
- Halt vs branch: halt_req=1 and ex_branch_taken=1 together -> flush taken, state stays RUN. Next cycle (branch low) -> HALT entered, halt_ack=1 the cycle after.
- Async reset mid-MDU_WAIT: rst pulse between clock edges -> mdu_busy=0, halt_ack=0 immediately. Counters read 0 after release.
